multicycle_cu: RTL

Parametrised multi-cycle successor to the single-cycle control unit. It sequences FETCH/DECODE/EXEC/MEM/WB through an FSM and owns the register file and PC. Instruction and data memories sit behind a req/ready handshake, so variable-latency memories are supported. The ALU is external and combinational. The block adds halt, illegal-opcode trap, a hardwired zero register and a retired-instruction counter.

---
 rtl/cu_pkg.sv | 46 ++++
 rtl/cu_regfile.sv | 31 +++
 rtl/multicycle_cu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction field positions and the link register index.
package cu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [4:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_ALU_LO = 6'h00;
  localparam logic [5:0] OP_ALU_HI = 6'h07;
  localparam logic [5:0] OP_BEQ    = 6'h08;
  localparam logic [5:0] OP_BNE    = 6'h09;
  localparam logic [5:0] OP_BGT    = 6'h0A;
  localparam logic [5:0] OP_BGE    = 6'h0B;
  localparam logic [5:0] OP_BLT    = 6'h0C;
  localparam logic [5:0] OP_BLE    = 6'h0D;
  localparam logic [5:0] OP_J      = 6'h10;
  localparam logic [5:0] OP_JR     = 6'h11;
  localparam logic [5:0] OP_JAL    = 6'h12;
  localparam logic [5:0] OP_SLT    = 6'h13;
  localparam logic [5:0] OP_SLTI   = 6'h14;
  localparam logic [5:0] OP_LW     = 6'h15;
  localparam logic [5:0] OP_SW     = 6'h16;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module cu_regfile #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           raddr_a,
  output logic [DATA_SIZE-1:0] rdata_a,
  input  logic [4:0]           raddr_b,
  output logic [DATA_SIZE-1:0] rdata_b,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [DATA_SIZE-1:0] wdata
);

  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that owns the
// pc and register file and talks to instruction/data memories via req/ready.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int PC_WIDTH  = 6,
  parameter int DATA_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [PC_WIDTH-1:0]  dmem_addr,
  output logic [DATA_SIZE-1:0] dmem_wdata,
  input  logic                 dmem_ready,
  input  logic [DATA_SIZE-1:0] dmem_rdata,
  output logic [5:0]           alu_opcode,
  output logic [5:0]           alu_funct,
  output logic [DATA_SIZE-1:0] alu_a,
  output logic [DATA_SIZE-1:0] alu_b,
  output logic [15:0]          alu_imm,
  input  logic [DATA_SIZE-1:0] alu_result,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 halted,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t               state;
  logic [31:0]          ir;
  logic [PC_WIDTH-1:0]  pc, pc_inc, br_target, ea, jmp_target, ctrl_pc;
  logic [5:0]           op;
  logic [4:0]           rs, rt, rd;
  logic [15:0]          imm;
  logic [DATA_SIZE-1:0] imm_sx, br_sum, ea_sum, link_val;
  logic [DATA_SIZE-1:0] wb_data, slt_val, slti_val;
  logic [DATA_SIZE-1:0] rf_a, rf_b, rf_wdata;
  logic [4:0]           rf_raddr_b, rf_waddr;
  logic                 rf_we, taken;
  logic                 unused_bits;

  assign op     = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign imm    = ir[IMM_HI:IMM_LO];
  assign imm_sx = {{(DATA_SIZE-16){imm[15]}}, imm};

  assign pc_out     = pc;
  assign imem_addr  = pc;
  assign pc_inc     = pc + PC_WIDTH'(1);
  assign link_val   = {{(DATA_SIZE-PC_WIDTH){1'b0}}, pc_inc};
  assign br_sum     = link_val + imm_sx;
  assign br_target  = br_sum[PC_WIDTH-1:0];
  assign ea_sum     = alu_a + imm_sx;
  assign ea         = ea_sum[PC_WIDTH-1:0];
  assign jmp_target = ir[PC_WIDTH-1:0];
  assign unused_bits = ^{br_sum[DATA_SIZE-1:PC_WIDTH], ea_sum[DATA_SIZE-1:PC_WIDTH]};

  assign slt_val  = {{(DATA_SIZE-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
  assign slti_val = {{(DATA_SIZE-1){1'b0}}, $signed(alu_a) < $signed(imm_sx)};

  // Operands are latched into alu_a/alu_b in DECODE, so EXEC compares them.
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (alu_a == alu_b);
      OP_BNE:  taken = (alu_a != alu_b);
      OP_BGT:  taken = $signed(alu_a) >  $signed(alu_b);
      OP_BGE:  taken = $signed(alu_a) >= $signed(alu_b);
      OP_BLT:  taken = $signed(alu_a) <  $signed(alu_b);
      OP_BLE:  taken = $signed(alu_a) <= $signed(alu_b);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_pc = pc_inc;
    case (op) inside
      [OP_BEQ:OP_BLE]: if (taken) ctrl_pc = br_target;
      OP_J, OP_JAL:    ctrl_pc = jmp_target;
      OP_JR:           ctrl_pc = alu_a[PC_WIDTH-1:0];
      default:         ctrl_pc = pc_inc;
    endcase
  end

  // Port b reads rt in DECODE and switches to rd in EXEC to fetch store data.
  assign rf_raddr_b = (state == S_EXEC) ? rd : rt;
  assign rf_we      = (state == S_WB) || (state == S_EXEC && op == OP_JAL);
  assign rf_waddr   = (state == S_EXEC) ? LINK_REG : rd;
  assign rf_wdata   = (state == S_EXEC) ? link_val : wb_data;

  cu_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_SIZE (DATA_SIZE)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rf_raddr_b),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      wb_data    <= '0;
      imem_req   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_imm    <= '0;
      halted     <= 1'b0;
      error      <= 1'b0;
      retired    <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) begin
          ir       <= imem_rdata;
          imem_req <= 1'b0;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          alu_opcode <= op;
          alu_funct  <= ir[FN_HI:FN_LO];
          alu_a      <= rf_a;
          alu_b      <= rf_b;
          alu_imm    <= imm;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          case (op) inside
            [OP_ALU_LO:OP_ALU_HI]: begin
              wb_data <= alu_result;
              state   <= S_WB;
            end
            OP_SLT: begin
              wb_data <= slt_val;
              state   <= S_WB;
            end
            OP_SLTI: begin
              wb_data <= slti_val;
              state   <= S_WB;
            end
            [OP_BEQ:OP_BLE], OP_J, OP_JR, OP_JAL: begin
              pc       <= ctrl_pc;
              retired  <= retired + CNT_WIDTH'(1);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              dmem_addr <= ea;
              dmem_we   <= (op == OP_SW);
              if (op == OP_SW) dmem_wdata <= rf_b;
              dmem_req  <= 1'b1;
              state     <= S_MEM;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              retired <= retired + CNT_WIDTH'(1);
              state   <= S_HALT;
            end
            default: begin
              halted <= 1'b1;
              error  <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_MEM: if (dmem_ready) begin
          dmem_req <= 1'b0;
          if (dmem_we) begin
            pc       <= pc_inc;
            retired  <= retired + CNT_WIDTH'(1);
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else begin
            wb_data <= dmem_rdata;
            state   <= S_WB;
          end
        end
        S_WB: begin
          pc       <= pc_inc;
          retired  <= retired + CNT_WIDTH'(1);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
